// File: rtl/sseg_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment patterns
// ({g,f,e,d,c,b,a}) and one-hot-low anode codes.
package sseg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    function automatic logic [3:0] an_for_slot(input slot_t slot);
        case (slot)
            2'd0:    return AN_D0;
            2'd1:    return AN_D1;
            2'd2:    return AN_D2;
            default: return AN_D3;
        endcase
    endfunction

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 render a dash.
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// 4-digit common-anode scan driver with frame-aligned digit snapshot and anode guard.
// Optional leading-zero blanking on digits 3..1: define SSEG_LEADING_ZERO_BLANK_EN.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int GUARD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int MSB = REFRESH_BITS - 1;
    localparam logic [MSB-2:0] GUARD_LIM = (REFRESH_BITS - 2)'(GUARD_CYCLES);

    logic [MSB:0]      cnt;
    logic [3:0][3:0]   shadow_d;
    logic [3:0]        shadow_dp;
    slot_t             sel;
    logic [MSB-2:0]    off;
    logic [6:0]        seg_dec;
    logic [6:0]        seg_g;
    logic [3:0]        an_next;
    logic [7:0]        sseg_next;

    assign sel = cnt[MSB -: 2];
    assign off = cnt[MSB-2:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    // Capture on the last count of a frame so the whole next frame sees one consistent set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shadow_d  <= '0;
            shadow_dp <= '0;
        end else if (&cnt) begin
            shadow_d  <= {d3, d2, d1, d0};
            shadow_dp <= dp_in;
        end
    end

    sseg_decoder u_dec (
        .bcd (shadow_d[sel]),
        .seg (seg_dec)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [3:0] is_zero;
    logic [3:0] blank;

    always_comb begin
        for (int i = 0; i < 4; i++) is_zero[i] = (shadow_d[i] == 4'd0);
        blank[3] = is_zero[3];
        blank[2] = is_zero[2] & blank[3];
        blank[1] = is_zero[1] & blank[2];
        blank[0] = 1'b0;
    end

    assign seg_g = blank[sel] ? SEG_BLANK : seg_dec;
`else
    assign seg_g = seg_dec;
`endif

    // NOTE: every branch assigns both outputs, so no latch can be inferred.
    always_comb begin
        an_next   = (off < GUARD_LIM) ? AN_OFF : an_for_slot(sel);
        sseg_next = {~shadow_dp[sel], seg_g};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an   <= AN_OFF;
            sseg <= 8'hFF;
        end else begin
            an   <= an_next;
            sseg <= sseg_next;
        end
    end

endmodule
